// File: rtl/tape_timing_gen_pkg.sv
// Shared constants for the DECtape timing helper: TCK width and the
// default divider derived from the system and tick clock rates.
package tape_timing_gen_pkg;

    localparam int TCK_W   = 2;
    localparam int CLK_HZ  = 50_000_000;
    localparam int TICK_HZ = 120_000;

    // Rounded divide: (50 MHz + 60 kHz) / 120 kHz = 417.
    localparam int DIV_DEFAULT   = (CLK_HZ + TICK_HZ / 2) / TICK_HZ;
    localparam int CNT_W_DEFAULT = 9;

    // TCK counts down modulo 4: 00 -> 11 -> 10 -> 01 -> 00.
    function automatic logic [TCK_W-1:0] tck_dec(input logic [TCK_W-1:0] v);
        return v - TCK_W'(1);
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: p is high while 'in' is 1 and its previous-clock
// sample was 0. History resets to RST_VAL so an idle input makes no pulse.
module edge_pulse #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic p
);

    logic in_d_q;

    // One-clock history of the input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_d_q <= RST_VAL;
        end else begin
            in_d_q <= in;
        end
    end

    assign p = in & ~in_d_q;

endmodule

// File: rtl/tape_timing_gen.sv
// DECtape timing helper: 120 kHz tick divider, 2-bit TCK timing-track
// counter held by wrtm_wait, and tp0/tp1 pulse generation from either the
// TCK edges (write-timing-mark mode) or the read-back timing track.
module tape_timing_gen
    import tape_timing_gen_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrtm,
    input  logic             wrtm_wait,
    input  logic             rwa_tm,
    output logic             tick120,
    output logic [TCK_W-1:0] tck,
    output logic             wr_tm,
    output logic             tp0,
    output logic             tp1
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic [TCK_W-1:0] tck_q, tck_d;

    logic tck_lsb_n;
    logic rwa_n;
    logic ftick;
    logic rrise;
    logic rfall;

    // Next-state for the free-running divider and the held TCK counter.
    always_comb begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
        tick_d    = 1'b0;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
        end
        // A tick arriving while the transport is not ready is dropped.
        tck_d = tck_q;
        if (tick_q && !wrtm_wait) begin
            tck_d = tck_dec(tck_q);
        end
    end

    // Divider, tick and TCK state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            tck_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            tck_q     <= tck_d;
        end
    end

    assign tck_lsb_n = ~tck_q[0];
    assign rwa_n     = ~rwa_tm;

    // TCK LSB fall; idle history is ~tck[0] at reset = 1.
    edge_pulse #(.RST_VAL(1'b1)) u_tck_fall (
        .clk   (clk),
        .reset (reset),
        .in    (tck_lsb_n),
        .p     (ftick)
    );

    // Timing-track rise; idle history rwa = 0.
    edge_pulse #(.RST_VAL(1'b0)) u_rwa_rise (
        .clk   (clk),
        .reset (reset),
        .in    (rwa_tm),
        .p     (rrise)
    );

    // Timing-track fall; history of ~rwa idles at 1.
    edge_pulse #(.RST_VAL(1'b1)) u_rwa_fall (
        .clk   (clk),
        .reset (reset),
        .in    (rwa_n),
        .p     (rfall)
    );

    // Pulse source select. tck[1] already holds the post-transition value
    // when ftick fires, so 11->10 gives tp1 and 01->00 gives tp0.
    always_comb begin
        tp0 = 1'b0;
        tp1 = 1'b0;
        if (wrtm) begin
            tp0 = ftick & ~tck_q[1];
            tp1 = ftick &  tck_q[1];
        end else begin
            tp0 = rfall;
            tp1 = rrise;
        end
    end

    assign tick120 = tick_q;
    assign tck     = tck_q;
    assign wr_tm   = tck_q[1];

endmodule

// File: tb/tb_tape_timing_gen.sv
// Directed bench for tape_timing_gen: a DIV=4 instance for the functional
// sequence and a default-DIV instance for the 417-clock tick period.
module tb_tape_timing_gen;

    logic       clk;
    logic       reset;
    logic       wrtm;
    logic       wrtm_wait;
    logic       rwa_tm;

    logic       s_tick, s_wr_tm, s_tp0, s_tp1;
    logic [1:0] s_tck;
    logic       d_tick, d_wr_tm, d_tp0, d_tp1;
    logic [1:0] d_tck;

    int n_cmp = 0;
    int n_bad = 0;

    tape_timing_gen #(.DIV(4), .CNT_W(2)) u_small (
        .clk       (clk),
        .reset     (reset),
        .wrtm      (wrtm),
        .wrtm_wait (wrtm_wait),
        .rwa_tm    (rwa_tm),
        .tick120   (s_tick),
        .tck       (s_tck),
        .wr_tm     (s_wr_tm),
        .tp0       (s_tp0),
        .tp1       (s_tp1)
    );

    tape_timing_gen u_def (
        .clk       (clk),
        .reset     (reset),
        .wrtm      (wrtm),
        .wrtm_wait (wrtm_wait),
        .rwa_tm    (rwa_tm),
        .tick120   (d_tick),
        .tck       (d_tck),
        .wr_tm     (d_wr_tm),
        .tp0       (d_tp0),
        .tp1       (d_tp1)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " tp0"}, 32'(s_tp0), 32'd0);
        check({tag, " tp1"}, 32'(s_tp1), 32'd0);
    endtask

    initial begin
        logic [1:0] tck_seq [4];
        int         lost;
        int         steps;
        int         cnt;
        bit         found;

        tck_seq = '{2'b00, 2'b11, 2'b10, 2'b01};

        reset     = 1'b1;
        wrtm      = 1'b0;
        wrtm_wait = 1'b0;
        rwa_tm    = 1'b0;

        // Reset values before any clock edge.
        #3;
        check("rst tick", 32'(s_tick), 32'd0);
        check("rst tck", 32'(s_tck), 32'd0);
        check("rst wr_tm", 32'(s_wr_tm), 32'd0);
        check_quiet("rst");
        check("rst def tick", 32'(d_tick), 32'd0);
        check("rst def tck", 32'(d_tck), 32'd0);
        step();
        step();
        check("rst held tick", 32'(s_tick), 32'd0);
        reset = 1'b0;

        // Edges numbered from release. Ticks follow edges 4,8,...; TCK moves
        // on the next edge. Read mode to 20, write mode after, wrtm_wait held
        // across the ticks at 36, 40, 44.
        for (int k = 1; k <= 53; k++) begin
            step();
            lost  = (k >= 45) ? 3 : (k >= 41) ? 2 : (k >= 37) ? 1 : 0;
            steps = (k - 1) / 4 - lost;
            check($sformatf("e%0d tick", k), 32'(s_tick), 32'((k % 4) == 0));
            check($sformatf("e%0d tck", k), 32'(s_tck), 32'(tck_seq[steps % 4]));
            check($sformatf("e%0d wr_tm", k), 32'(s_wr_tm), 32'(tck_seq[steps % 4] >> 1));
            check($sformatf("e%0d tp1", k), 32'(s_tp1), 32'((k == 25) || (k == 53)));
            check($sformatf("e%0d tp0", k), 32'(s_tp0), 32'(k == 33));
            if (k == 20) wrtm = 1'b1;
            if (k == 36) wrtm_wait = 1'b1;
            if (k == 45) wrtm_wait = 1'b0;
        end

        // Asynchronous reset mid-cycle while tck = 10 and tp1 is high.
        #2;
        reset = 1'b1;
        #1;
        check("arst tck", 32'(s_tck), 32'd0);
        check("arst tick", 32'(s_tick), 32'd0);
        check_quiet("arst");
        step();
        step();
        check("arst held tck", 32'(s_tck), 32'd0);
        reset = 1'b0;

        // After release: no spurious pulses, tick/TCK restart from zero.
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("r%0d tick", k), 32'(s_tick), 32'((k % 4) == 0));
            check($sformatf("r%0d tck", k), 32'(s_tck), (k >= 5) ? 32'd3 : 32'd0);
            check_quiet($sformatf("r%0d", k));
        end

        // Read mode: the 11->10 fall at the next edge must not reach tp1.
        wrtm = 1'b0;
        step();
        check("rd tck", 32'(s_tck), 32'd2);
        check_quiet("rd masked");

        // Timing-track rise: one-cycle tp1.
        rwa_tm = 1'b1;
        #1;
        check("rise tp1", 32'(s_tp1), 32'd1);
        check("rise tp0", 32'(s_tp0), 32'd0);
        for (int j = 1; j <= 5; j++) begin
            step();
            check_quiet($sformatf("high%0d", j));
        end

        // Timing-track fall: one-cycle tp0.
        rwa_tm = 1'b0;
        #1;
        check("fall tp0", 32'(s_tp0), 32'd1);
        check("fall tp1", 32'(s_tp1), 32'd0);
        step();
        check_quiet("after fall");

        // Default divider: 10 consecutive tick periods of 417 clocks.
        found = 1'b0;
        for (int j = 0; j < 1000 && !found; j++) begin
            step();
            if (d_tick) found = 1'b1;
        end
        check("def first tick seen", 32'(found), 32'd1);
        if (found) begin
            for (int p = 0; p < 10; p++) begin
                cnt   = 0;
                found = 1'b0;
                while (cnt < 1000 && !found) begin
                    step();
                    cnt++;
                    if (d_tick) found = 1'b1;
                end
                check($sformatf("def period %0d", p), 32'(cnt), 32'd417);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
